// File: rtl/scu_stream.sv
// Sparse convolution stream unit: gathers activations per sparse lane, multiplies by
// weights in a two-stage pipeline and drains banked accumulators with shift/saturate.
module scu_stream #(
  parameter int A_BITS   = 12,
  parameter int W_BITS   = 16,
  parameter int I_BITS   = 6,
  parameter int ACC_BITS = 32,
  parameter int N_W      = 18,
  parameter int N_ACT    = 36,
  parameter int N_OC     = 3,
  parameter int N_OUT    = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       mode,
  input  logic [15:0]                                cfg_beats,
  input  logic [5:0]                                 cfg_shift,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [N_W-1:0][W_BITS-1:0]                 weights,
  input  logic [N_W-1:0][I_BITS-1:0]                 indexes,
  input  logic [N_ACT-1:0][A_BITS-1:0]               input_tile,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [((N_OC > 1) ? $clog2(N_OC) : 1)-1:0] out_bank,
  output logic [N_OUT-1:0][A_BITS-1:0]               out_data,
  output logic                                       busy,
  output logic                                       done
);

  localparam int P_BITS         = A_BITS + W_BITS;
  localparam int N_ACC          = N_OC * N_OUT;
  localparam int ADDR_BITS      = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int BANK_BITS      = (N_OC > 1) ? $clog2(N_OC) : 1;
  localparam int LANES_PER_BANK = N_W / N_OC;
  localparam logic signed [ACC_BITS-1:0] SAT_HI = ACC_BITS'((2 ** (A_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [15:0]              beats_q, beats_d;
  logic [15:0]              beatCnt_q, beatCnt_d;
  logic [5:0]               shift_q, shift_d;
  logic                     flushCnt_q, flushCnt_d;
  logic [BANK_BITS-1:0]     bank_q, bank_d;
  logic                     done_q;

  logic signed [P_BITS-1:0] prod_q [N_W];
  logic signed [P_BITS-1:0] prod_d [N_W];
  logic [ADDR_BITS-1:0]     dest_q [N_W];
  logic [ADDR_BITS-1:0]     dest_d [N_W];
  logic [N_W-1:0]           laneVld_q, laneVld_d;
  logic [ACC_BITS-1:0]      acc_q [N_ACC];
  logic [ACC_BITS-1:0]      acc_d [N_ACC];

  logic accept, outHs, finalHs;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    beats_d    = beats_q;
    shift_d    = shift_q;
    beatCnt_d  = beatCnt_q;
    flushCnt_d = flushCnt_q;
    bank_d     = bank_q;
    accept     = (state_q == ACCUM) && in_valid;
    outHs      = (state_q == DRAIN) && out_ready;
    finalHs    = outHs && (bank_q == BANK_BITS'(N_OC - 1));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          mode_d    = mode;
          beats_d   = (cfg_beats == 16'd0) ? 16'd1 : cfg_beats;
          shift_d   = cfg_shift;
          beatCnt_d = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          beatCnt_d = beatCnt_q + 16'd1;
          if (beatCnt_d == beats_q) begin
            state_d    = FLUSH;
            flushCnt_d = 1'b0;
          end
        end
      end
      // Two idle cycles let the last accepted beat retire through both pipeline stages.
      FLUSH: begin
        flushCnt_d = 1'b1;
        if (flushCnt_q) begin
          state_d = DRAIN;
          bank_d  = '0;
        end
      end
      DRAIN: begin
        if (outHs) begin
          bank_d = bank_q + BANK_BITS'(1);
          if (finalHs) begin
            state_d = IDLE;
            bank_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int effIdx;
    int limit;
    int dest;
    logic signed [A_BITS-1:0] act;
    logic signed [P_BITS-1:0] actExt;
    logic signed [P_BITS-1:0] wExt;
    for (int k = 0; k < N_W; k++) begin
      effIdx = mode_q ? (int'(indexes[k]) % N_OUT) : int'(indexes[k]);
      limit  = mode_q ? N_OUT : N_ACT;
      act    = '0;
      for (int j = 0; j < N_ACT; j++) begin
        if (j == effIdx && j < limit) act = input_tile[j];
      end
      actExt       = {{W_BITS{act[A_BITS-1]}}, act};
      wExt         = {{A_BITS{weights[k][W_BITS-1]}}, weights[k]};
      prod_d[k]    = actExt * wExt;
      dest         = mode_q ? (k / LANES_PER_BANK) * N_OUT + effIdx : effIdx;
      dest_d[k]    = ADDR_BITS'(dest);
      laneVld_d[k] = accept && (dest < N_ACC);
    end
  end

  // Every lane aimed at an address contributes in the same cycle, so collisions simply sum.
  always_comb begin
    for (int a = 0; a < N_ACC; a++) begin
      acc_d[a] = acc_q[a];
      for (int k = 0; k < N_W; k++) begin
        if (laneVld_q[k] && dest_q[k] == ADDR_BITS'(a))
          acc_d[a] = acc_d[a] + {{(ACC_BITS - P_BITS){prod_q[k][P_BITS-1]}}, prod_q[k]};
      end
      if (finalHs) acc_d[a] = '0;
    end
  end

  always_comb begin
    logic signed [ACC_BITS-1:0] sel;
    logic signed [ACC_BITS-1:0] shifted;
    for (int t = 0; t < N_OUT; t++) begin
      sel = '0;
      for (int b = 0; b < N_OC; b++) begin
        if (bank_q == BANK_BITS'(b)) sel = acc_q[b * N_OUT + t];
      end
      shifted = sel >>> shift_q;
      if (state_q != DRAIN)      out_data[t] = '0;
      else if (shifted > SAT_HI) out_data[t] = SAT_HI[A_BITS-1:0];
      else if (shifted < SAT_LO) out_data[t] = SAT_LO[A_BITS-1:0];
      else                       out_data[t] = shifted[A_BITS-1:0];
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign out_bank  = bank_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      beats_q    <= '0;
      shift_q    <= '0;
      beatCnt_q  <= '0;
      flushCnt_q <= 1'b0;
      bank_q     <= '0;
      done_q     <= 1'b0;
      laneVld_q  <= '0;
      for (int k = 0; k < N_W; k++) begin
        prod_q[k] <= '0;
        dest_q[k] <= '0;
      end
      for (int a = 0; a < N_ACC; a++) acc_q[a] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      beats_q    <= beats_d;
      shift_q    <= shift_d;
      beatCnt_q  <= beatCnt_d;
      flushCnt_q <= flushCnt_d;
      bank_q     <= bank_d;
      done_q     <= finalHs;
      laneVld_q  <= laneVld_d;
      for (int k = 0; k < N_W; k++) begin
        prod_q[k] <= prod_d[k];
        dest_q[k] <= dest_d[k];
      end
      for (int a = 0; a < N_ACC; a++) acc_q[a] <= acc_d[a];
    end
  end

endmodule

// File: tb/tb_scu_stream.sv
// Directed self-checking bench for scu_stream: banked gather/accumulate, saturation,
// input throttling, output back-pressure and mid-job reset.
module tb_scu_stream;
  localparam int A_BITS = 12, W_BITS = 16, I_BITS = 6, ACC_BITS = 32;
  localparam int N_W = 18, N_ACT = 36, N_OC = 3, N_OUT = 16;
  localparam int N_ACC = N_OC * N_OUT;

  logic clk = 1'b0;
  logic rst, start, mode, in_valid, out_ready;
  logic [15:0] cfg_beats;
  logic [5:0] cfg_shift;
  logic in_ready, out_valid, busy, done;
  logic [N_W-1:0][W_BITS-1:0] weights;
  logic [N_W-1:0][I_BITS-1:0] indexes;
  logic [N_ACT-1:0][A_BITS-1:0] input_tile;
  logic [1:0] out_bank;
  logic [N_OUT-1:0][A_BITS-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int expAcc[N_ACC];

  always #5 clk = ~clk;

  scu_stream #(
    .A_BITS(A_BITS), .W_BITS(W_BITS), .I_BITS(I_BITS), .ACC_BITS(ACC_BITS),
    .N_W(N_W), .N_ACT(N_ACT), .N_OC(N_OC), .N_OUT(N_OUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cfg_beats(cfg_beats),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
    .weights(weights), .indexes(indexes), .input_tile(input_tile),
    .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
    .out_data(out_data), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int expOut(input int acc, input int sh);
    int v;
    v = acc >>> sh;
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic clearVectors();
    weights = '0;
    indexes = '0;
    input_tile = '0;
    for (int a = 0; a < N_ACC; a++) expAcc[a] = 0;
  endtask

  // Lanes index k mod 6 inside their bank; with unit weights bank b position t holds t.
  task automatic setBankVectors(input int w);
    clearVectors();
    for (int k = 0; k < N_W; k++) begin
      weights[k] = W_BITS'(w);
      indexes[k] = I_BITS'(k % 6);
    end
    for (int i = 0; i < N_ACT; i++) input_tile[i] = A_BITS'(i);
    for (int b = 0; b < N_OC; b++)
      for (int t = 0; t < 6; t++) expAcc[b * N_OUT + t] = t * w;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_bank"}, int'(out_bank), 0);
    checkOutput({tag, "_out_data0"}, int'(out_data[0]), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  task automatic startJob(input logic m, input int beats, input int sh);
    mode = m;
    cfg_beats = 16'(beats);
    cfg_shift = 6'(sh);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_busy", int'(busy), 1);
  endtask

  task automatic applyStimulus();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("in_ready_wait", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drainAndCheck(input int sh, input int holdCycles);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput("drain_wait", int'(out_valid), 1);
      return;
    end
    for (int b = 0; b < N_OC; b++) begin
      if (b == 0) begin
        out_ready = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
          checkOutput($sformatf("hold%0d_valid", h), int'(out_valid), 1);
          checkOutput($sformatf("hold%0d_bank", h), int'(out_bank), 0);
          checkOutput($sformatf("hold%0d_data0", h), $signed(out_data[0]), expOut(expAcc[0], sh));
          @(negedge clk);
        end
      end
      checkOutput($sformatf("bank%0d_valid", b), int'(out_valid), 1);
      checkOutput($sformatf("bank%0d_id", b), int'(out_bank), b);
      for (int t = 0; t < N_OUT; t++)
        checkOutput($sformatf("bank%0d_data%0d", b, t), $signed(out_data[t]),
                    expOut(expAcc[b * N_OUT + t], sh));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    checkOutput("final_done", int'(done), 1);
    checkOutput("final_busy", int'(busy), 0);
    checkOutput("final_out_valid", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("done_single_pulse", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int hit4;
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    cfg_beats = '0;
    cfg_shift = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clearVectors();
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] banked gather, mode 1");
    setBankVectors(1);
    startJob(1'b1, 1, 0);
    applyStimulus();
    drainAndCheck(0, 0);

    $display("[TB] flat collisions, mode 0, saturating and shifted");
    for (int pass = 0; pass < 2; pass++) begin
      clearVectors();
      for (int k = 0; k < N_W; k++) begin
        weights[k] = W_BITS'(2);
        indexes[k] = I_BITS'(35);
      end
      input_tile[35] = A_BITS'(100);
      expAcc[35] = 7200;
      startJob(1'b0, 2, pass * 2);
      applyStimulus();
      applyStimulus();
      drainAndCheck(pass * 2, 0);
    end

    $display("[TB] negative saturation, zero beat count");
    clearVectors();
    weights[0] = W_BITS'(-2500);
    input_tile[0] = A_BITS'(2000);
    expAcc[0] = -5000000;
    startJob(1'b1, 0, 4);
    applyStimulus();
    drainAndCheck(4, 0);

    $display("[TB] toggled in_valid, back-pressure on drain");
    clearVectors();
    weights[0] = W_BITS'(1);
    input_tile[0] = A_BITS'(10);
    expAcc[0] = 40;
    startJob(1'b1, 4, 0);
    accepted = 0;
    hit4 = -10;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      if (i == hit4 + 1) begin
        checkOutput("flush_in_ready", int'(in_ready), 0);
        checkOutput("flush_busy", int'(busy), 1);
        checkOutput("flush_out_valid", int'(out_valid), 0);
      end
      if (in_valid && in_ready) begin
        accepted++;
        if (accepted == 4) hit4 = i;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("beats_accepted", accepted, 4);
    drainAndCheck(0, 5);

    $display("[TB] reset mid-accumulation");
    setBankVectors(5);
    startJob(1'b1, 3, 0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst = 1'b0;
    @(negedge clk);
    setBankVectors(1);
    startJob(1'b1, 1, 0);
    applyStimulus();
    drainAndCheck(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/scu_stream.md
SCU_STREAM -- requirements
Module: scu_stream

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- A_BITS, 12, activation and output data width
- W_BITS, 16, weight width
- I_BITS, 6, sparse index width
- ACC_BITS, 32, accumulator width
- N_W, 18, sparse weight/index lanes per beat; multiple of N_OC
- N_ACT, 36, activation tile entries; N_ACT <= N_OC*N_OUT
- N_OC, 3, output-channel banks
- N_OUT, 16, outputs per bank; power of two

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge
- rst, in, 1, synchronous active-high reset
- start, in, 1, begin a job; sampled only in IDLE
- mode, in, 1, 1 = Rfconv (N_OC channels), 0 = Rfdeconv (single flat bank); latched on start
- cfg_beats, in, 16, number of input beats per job; latched on start; 0 is treated as 1
- cfg_shift, in, 6, arithmetic right shift applied on drain; latched on start
- in_valid, in, 1, input beat valid
- in_ready, out, 1, block accepts a beat
- weights, in, N_W x W_BITS signed, sparse weights
- indexes, in, N_W x I_BITS, activation/accumulator index per lane
- input_tile, in, N_ACT x A_BITS signed, activation tile
- out_valid, out, 1, drained bank is valid
- out_ready, in, 1, consumer accepts the bank
- out_bank, out, $clog2(N_OC), index of the bank being drained
- out_data, out, N_OUT x A_BITS signed, drained bank values
- busy, out, 1, high whenever state != IDLE
- done, out, 1, one-cycle pulse after the final bank handshake

Function
REQ-003 The FSM SHALL have states IDLE, ACCUM, FLUSH and DRAIN; transitions: IDLE->ACCUM on start; ACCUM->FLUSH on the acceptance of beat cfg_beats; FLUSH->DRAIN after exactly 2 cycles; DRAIN->IDLE on the handshake of bank N_OC-1.
REQ-004 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid && in_ready; a beat counter increments per accepted beat.
REQ-005 Gather: for lane k, eff_idx SHALL equal indexes[k] mod N_OUT when mode=1, and indexes[k] when mode=0; activations at or above N_OUT in mode=1 and at or above N_ACT in mode=0 SHALL read as 0.
REQ-006 Stage 1 SHALL register the full-precision signed product (A_BITS+W_BITS bits) of each lane on the cycle the beat is accepted; stage 2 SHALL sign-extend the product to ACC_BITS and add it to the accumulator on the next cycle.
REQ-007 Destination address: in mode=1, lane k SHALL target (k / (N_W/N_OC))*N_OUT + eff_idx; in mode=0, lane k SHALL target eff_idx, and lanes with eff_idx >= N_OC*N_OUT SHALL be dropped.
REQ-008 Lanes hitting the same address in one cycle SHALL all be summed; accumulator addition SHALL wrap modulo 2^ACC_BITS.
REQ-009 In DRAIN, out_valid SHALL be 1 and out_bank SHALL equal b, starting at 0; out_data[t] SHALL equal the accumulator at b*N_OUT+t, arithmetic-shifted right by cfg_shift and saturated to the signed A_BITS range.
REQ-010 out_bank and out_data SHALL stay stable while out_valid && !out_ready; b SHALL advance on each handshake.
REQ-011 On the final handshake, all accumulators SHALL clear to 0 and done SHALL pulse on the following cycle, in IDLE.
REQ-012 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside ACCUM.

Reset
REQ-013 While rst=1 at a clock edge, the block SHALL enter IDLE, zero all accumulators, pipeline registers and counters, and drive in_ready=0, out_valid=0, out_bank=0, out_data=0, busy=0 and done=0.
REQ-014 Reset SHALL take priority over every other event, including mid-ACCUM and mid-DRAIN; the first job after reset SHALL see zero accumulators.

Verification
REQ-015 The bench SHALL cover these scenarios:
- mode=1, cfg_beats=1, cfg_shift=0, all weights=1, indexes[k]=k mod 6, input_tile[i]=i -> each bank b holds values 0..5 at t=0..5 and 0 elsewhere; done pulses once.
- mode=0, all 18 lanes index 35, activation[35]=100, weights=2, cfg_beats=2 -> accumulator 35 (bank 2, t=3) equals 7200 >> shift; with cfg_shift=0 the output saturates to 2047.
- Negative saturation: a single lane with product -5000000 and cfg_shift=4 -> out_data=-2048.
- in_valid toggled 1/0 with cfg_beats=4 -> exactly 4 beats accepted; in_ready=0 in FLUSH.
- out_ready held low for 5 cycles in DRAIN -> out_bank and out_data stable, with no bank skipped.
- rst asserted mid-ACCUM -> all outputs take their reset values next cycle; the next job's result equals a fresh run.
